// File: rtl/projection_sequencer.sv
// projection_sequencer: frame-level controller for the 3D-to-2D projection
// datapath. Latches the camera for a frame, issues model RAM addresses under
// credit control, buffers results in a first-word-fall-through FIFO and hands
// them downstream on a valid/ready port.
// Optional build macro: SEQ_WATCHDOG_EN (return-timeout watchdog).
//
// Handshake: a triangle transfers on any clock edge where tri_valid and
// tri_ready are both 1; while tri_valid=1 and tri_ready=0, tri_data and
// tri_last hold. issue_valid/proj_valid are one-cycle strobes with no stall.
module projection_sequencer #(
  parameter int SIZE       = 4,
  parameter int ADDRW      = $clog2(SIZE),
  parameter int PIPE_LAT   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [29:0]      camera_loc_in,
  output logic [29:0]      camera_loc,
  output logic [ADDRW-1:0] ram_addr,
  output logic             issue_valid,
  input  logic             proj_valid,
  input  logic [63:0]      proj_data,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [63:0]      tri_data,
  output logic             tri_last,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  // wide enough for fifo_count + inflight (each at most FIFO_DEPTH)
  localparam int CNTW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int RETW = $clog2(SIZE + 1);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PIPE_LAT < 1) begin : g_bad_param
    $error("projection_sequencer: FIFO_DEPTH must be a power of two >= 2 and PIPE_LAT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDRW-1:0] issue_cnt;
  logic [RETW-1:0]  ret_cnt;
  logic [CNTW-1:0]  inflight;
  logic [CNTW-1:0]  fifo_count;
  logic [CNTW-1:0]  occupancy;
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [64:0]      mem [FIFO_DEPTH];

  logic start_acc, has_credit, push_req, push, pop, full, drop, overflow, wd_fire;

  assign start_acc  = (state == IDLE) && frame_start;
  assign occupancy  = fifo_count + inflight;
  assign has_credit = occupancy < CNTW'(FIFO_DEPTH);
  assign full       = fifo_count == CNTW'(FIFO_DEPTH);
  // a return is only legitimate while something is outstanding
  assign push_req   = proj_valid && (inflight != '0);
  assign drop       = proj_valid && (inflight == '0);
  assign pop        = tri_valid && tri_ready;
  assign push       = push_req && (!full || pop);
  assign overflow   = push_req && full && !pop;

  assign ram_addr  = issue_cnt;
  assign tri_valid = fifo_count != '0;
  assign tri_data  = mem[rd_ptr][63:0];
  assign tri_last  = tri_valid && mem[rd_ptr][64];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and per-state strobes
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    frame_done  = 1'b0;
    issue_valid = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        issue_valid = has_credit;
        if (wd_fire)                                state_nxt = DONE;
        else if (has_credit && issue_cnt == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wd_fire) state_nxt = DONE;
        else if (ret_cnt == RETW'(SIZE) && pop && tri_last) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // camera latch, issue/return/inflight counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      camera_loc <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      inflight   <= '0;
      err        <= 1'b0;
    end else begin
      if (start_acc) begin
        camera_loc <= camera_loc_in;
        issue_cnt  <= '0;
        ret_cnt    <= '0;
      end else begin
        // the address counter stops on the last address so ram_addr holds
        if (issue_valid && issue_cnt != LAST_ADDR) issue_cnt <= issue_cnt + 1'b1;
        if (push_req) ret_cnt <= ret_cnt + 1'b1;
      end
      if (wd_fire) inflight <= '0;
      else         inflight <= inflight + CNTW'(issue_valid) - CNTW'(push_req);
      if (drop || overflow || wd_fire) err <= 1'b1;
      else if (start_acc)              err <= 1'b0;
    end
  end

  // FIFO pointers and fill level; a watchdog abort empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (wd_fire) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
    end
  end

  // FIFO storage: data plus the end-of-frame tag
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(ret_cnt == RETW'(SIZE - 1)), proj_data};
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(2 * PIPE_LAT + 1);
  logic [WDW-1:0] wd_cnt;

  // cycles since the last return while results are outstanding; the abort
  // edge is the one on which it would reach 2*PIPE_LAT, so frame_done lands
  // exactly 2*PIPE_LAT cycles after the last return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    wd_cnt <= '0;
    else if (proj_valid)                           wd_cnt <= WDW'(1);
    else if (inflight == '0 || wd_fire || !busy)   wd_cnt <= '0;
    else                                           wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_fire = (state == ISSUE || state == DRAIN) && !proj_valid &&
                   (inflight != '0) && (wd_cnt == WDW'(2 * PIPE_LAT - 1));
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_projection_sequencer.sv
// Bench for projection_sequencer: a fixed-latency datapath model, a scoreboard
// queue of expected triangles, a table of frame scenarios and hand-written
// sequences for spurious returns, mid-frame reset and the watchdog.
`timescale 1ns/1ps
module tb_projection_sequencer;
  localparam int SIZE = 4;
  localparam int ADDRW = 2;
  localparam int PIPE_LAT = 8;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [29:0]      camera_loc_in = '0;
  logic [29:0]      camera_loc;
  logic [ADDRW-1:0] ram_addr;
  logic             issue_valid;
  logic             proj_valid = 1'b0;
  logic [63:0]      proj_data = '0;
  logic             tri_valid;
  logic             tri_ready = 1'b1;
  logic [63:0]      tri_data;
  logic             tri_last;
  logic             busy;
  logic             frame_done;
  logic             err;

  projection_sequencer #(.SIZE(SIZE), .ADDRW(ADDRW), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .camera_loc_in(camera_loc_in),
    .camera_loc(camera_loc), .ram_addr(ram_addr), .issue_valid(issue_valid),
    .proj_valid(proj_valid), .proj_data(proj_data), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .tri_data(tri_data), .tri_last(tri_last),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [63:0] make_data(input int f, input int a, input logic [31:0] r);
    return {f[15:0], a[7:0], 8'h5a, r};
  endfunction

  // datapath model + monitor + scoreboard, all on the falling edge
  typedef struct packed { logic v; logic [63:0] d; } pipe_t;
  pipe_t pipe [PIPE_LAT+1] = '{default: '0};
  logic [64:0] exp_q[$];
  int   fid = 0, n_issue = 0, n_supp = 0, n_beats = 0;
  int   done_cnt = 0, done_cyc = 0;
  int   supp_idx = -1;
  logic busy_at_done = 1'b0, err_at_done = 1'b0;
  logic inject = 1'b0;

  always @(negedge clk) begin
    pipe_t       nw;
    logic [31:0] r;
    logic [64:0] e;
    nw = '0;
    if (!rst_n) exp_q.delete();
    if (rst_n && frame_start && !busy && !frame_done) begin
      fid++; n_issue = 0; n_supp = 0; n_beats = 0;
    end
    if (issue_valid) begin
      check("issue_addr", 65'(ram_addr), 65'(n_issue));
      r = $urandom;
      if (n_issue == supp_idx) n_supp++;
      else begin
        nw.v = 1'b1;
        nw.d = make_data(fid, int'(ram_addr), r);
        exp_q.push_back({(n_issue - n_supp == SIZE - 1), make_data(fid, n_issue, r)});
      end
      n_issue++;
    end
    if (tri_valid && tri_ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tri_beat: got %h expected no beat (cycle %0d)", {tri_last, tri_data}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tri_beat", {tri_last, tri_data}, e);
      end
    end
    if (frame_done) begin
      done_cnt++; done_cyc = cyc; busy_at_done = busy; err_at_done = err;
    end
    for (int i = PIPE_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]    = nw;
    proj_valid = pipe[PIPE_LAT].v | inject;
    proj_data  = pipe[PIPE_LAT].d;
  end

  typedef struct {
    logic [29:0] cam;
    int          ready_low;
    logic        ready_rand;
    logic [29:0] dup_cam;
    int          dup_at;
    int          exp_beats;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  // drive one frame and check it against the vector's expectations
  task automatic run_frame(input vec_t v);
    int s, d0, t;
    @(posedge clk); #2;
    camera_loc_in = v.cam;
    frame_start   = 1'b1;
    tri_ready     = (v.ready_low == 0);
    s  = cyc;
    d0 = done_cnt;
    for (t = 1; t <= 300 && done_cnt == d0; t++) begin
      @(posedge clk); #2;
      frame_start   = 1'b0;
      camera_loc_in = 30'($urandom);
      if (t == v.dup_at) begin
        frame_start   = 1'b1;
        camera_loc_in = v.dup_cam;
      end
      if (t == 1) begin
        check("camera_at_c1", 65'(camera_loc), 65'(v.cam));
        check("busy_at_c1", 65'(busy), 65'(1));
        check("err_cleared", 65'(err), 65'(0));
      end
      if (v.ready_low > 20 && t == 30) begin
        check("bp_issue_valid", 65'(issue_valid), 65'(0));
        check("bp_addr_hold", 65'(ram_addr), 65'(SIZE - 1));
        check("bp_issue_count", 65'(n_issue), 65'(FIFO_DEPTH));
        check("bp_tri_valid", 65'(tri_valid), 65'(1));
      end
      if (t >= v.ready_low) tri_ready = v.ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("frame_done_seen", 65'(done_cnt - d0), 65'(1));
    if (v.exp_done != 0) check("done_cycle", 65'(done_cyc - s), 65'(v.exp_done));
    check("busy_at_done", 65'(busy_at_done), 65'(0));
    check("err_at_done", 65'(err_at_done), 65'(v.exp_err));
    check("issue_total", 65'(n_issue), 65'(SIZE));
    check("beat_total", 65'(n_beats), 65'(v.exp_beats));
    check("scoreboard_empty", 65'(exp_q.size()), 65'(0));
    check("camera_held", 65'(camera_loc), 65'(v.cam));
    check("fifo_empty_end", 65'(tri_valid), 65'(0));
    tri_ready = 1'b1;
  endtask

  vec_t tbl [4];
  vec_t plain;
`ifdef SEQ_WATCHDOG_EN
  vec_t wd_vec;
`endif

  initial begin
    tbl[0] = '{30'h1234_5678, 0,  1'b0, 30'h0,         0, 4, 1'b0, 14};
    tbl[1] = '{30'h2ABC_DEF1, 40, 1'b0, 30'h0,         0, 4, 1'b0, 44};
    tbl[2] = '{30'h0F0F_0F0F, 0,  1'b0, 30'h3FFF_FFFF, 3, 4, 1'b0, 14};
    tbl[3] = '{30'h1555_AAAA, 2,  1'b1, 30'h0,         0, 4, 1'b0, 0};
    plain  = '{30'h0123_4567, 0,  1'b0, 30'h0,         0, 4, 1'b0, 14};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_camera_loc", 65'(camera_loc), 65'(0));
    check("rst_ram_addr", 65'(ram_addr), 65'(0));
    check("rst_issue_valid", 65'(issue_valid), 65'(0));
    check("rst_tri_valid", 65'(tri_valid), 65'(0));
    check("rst_tri_last", 65'(tri_last), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_frame_done", 65'(frame_done), 65'(0));
    check("rst_err", 65'(err), 65'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // table of frame scenarios
    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // spurious return while idle
    @(posedge clk); #2;
    inject = 1'b1;
    @(posedge clk); #2;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("spurious_no_tri", 65'(tri_valid), 65'(0));
    check("spurious_err", 65'(err), 65'(1));
    check("spurious_idle", 65'(busy), 65'(0));
    run_frame(plain);

    // asynchronous reset after two issues
    @(posedge clk); #2;
    camera_loc_in = 30'h2222_3333;
    frame_start   = 1'b1;
    @(posedge clk); #2;
    frame_start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("pre_reset_issues", 65'(n_issue), 65'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 65'(busy), 65'(0));
    check("mid_rst_issue_valid", 65'(issue_valid), 65'(0));
    check("mid_rst_tri_valid", 65'(tri_valid), 65'(0));
    check("mid_rst_camera", 65'(camera_loc), 65'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("stale_return_err", 65'(err), 65'(1));
    check("stale_return_no_tri", 65'(tri_valid), 65'(0));
    run_frame(plain);

`ifdef SEQ_WATCHDOG_EN
    // lost return of address 2: abort 16 cycles after the last return
    wd_vec   = '{30'h0ABC_0123, 0, 1'b0, 30'h0, 0, 3, 1'b1, 28};
    supp_idx = 2;
    run_frame(wd_vec);
    supp_idx = -1;
    @(posedge clk); #2;
    check("wd_back_idle", 65'(busy), 65'(0));
    check("wd_fifo_empty", 65'(tri_valid), 65'(0));
    run_frame(plain);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop if the run ever stalls outright
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish within 500000 ns");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/projection_sequencer.md
Name: projection_sequencer

Overview:
- Frame-level controller for the 3D-to-2D projection datapath.
- On frame start it latches the camera location and holds it stable for the whole frame.
- It walks model RAM addresses 0..SIZE-1, pacing issue with credits because the datapath has no stall input. Projected triangles are buffered in an internal FIFO and handed downstream over a valid/ready interface.
- Sits between the frame/camera control logic and the rasteriser.

Parameters:
- SIZE, 4, number of triangles in model RAM.
- ADDRW, $clog2(SIZE), model RAM address width.
- PIPE_LAT, 8, cycles from issue_valid to the matching proj_valid. Fixed by the datapath; used only by the watchdog.
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse: begin a frame.
- camera_loc_in  in  30  camera {theta[29:21], x[20:14], y[13:7], z[6:0]}; sampled on accepted frame_start.
- camera_loc  out  30  latched camera location to datapath.
- ram_addr  out  ADDRW  model RAM address to datapath.
- issue_valid  out  1  datapath valid_in.
- proj_valid  in  1  datapath valid_out.
- proj_data  in  64  datapath model_out.
- tri_valid  out  1  FIFO head valid.
- tri_ready  in  1  downstream accept.
- tri_data  out  64  FIFO head data.
- tri_last  out  1  head entry is triangle SIZE-1 of the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- err  out  1  sticky error flag.

Behaviour:
- Reset values (async, rst_n=0): camera_loc=0, ram_addr=0, issue_valid=0, tri_valid=0, tri_last=0, busy=0, frame_done=0, err=0. FIFO is emptied, all counters are 0, state=IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - frame_start=1 at edge t latches camera_loc_in into camera_loc, clears issue/return counters, moves to ISSUE.
  - busy=1 from t+1. err is cleared on acceptance.
  - frame_start outside IDLE is ignored.
- ISSUE:
  - credit = FIFO_DEPTH - (fifo_count + inflight).
  - If credit>0: issue_valid=1 with ram_addr=issue_cnt for exactly one cycle, then issue_cnt increments.
  - If credit=0: issue_valid=0 and ram_addr holds.
  - After address SIZE-1 is issued, move to DRAIN. The first issue occurs at t+1.
- Inflight counter:
  - +1 on issue_valid, -1 on proj_valid; both in the same cycle leaves it unchanged.
- Return path:
  - proj_valid writes proj_data into the FIFO with a tag last = (ret_cnt==SIZE-1), then ret_cnt increments.
  - proj_valid while inflight=0 is dropped and sets err.
  - FIFO overflow is impossible by credit construction. If it occurs anyway, the data is dropped and err is set.
- FIFO:
  - Registered head, first-word-fall-through: tri_valid=1 the cycle after the write into an empty FIFO.
  - Simultaneous push and pop allowed when full or empty+1.
  - tri_data and tri_last are stable while tri_valid=1 and tri_ready=0.
- DRAIN:
  - Wait until ret_cnt=SIZE and the last-tagged entry is popped (tri_valid & tri_ready & tri_last), then go to DONE.
- DONE:
  - frame_done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - frame_start on the DONE cycle is ignored.
- camera_loc is unchanged from acceptance until the next accepted frame_start.
- Reset mid-frame: everything returns to reset values immediately. In-flight datapath results arriving after reset are dropped and set err.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro:
  - A counter runs while inflight>0; it resets on every proj_valid.
  - When it reaches 2*PIPE_LAT: set err, flush the FIFO, drive tri_valid=0, emit frame_done, and go to IDLE through DONE.
- Without the macro: no counter; a missing return stalls the sequencer in ISSUE/DRAIN indefinitely, and err comes only from the drop/overflow cases.

Test Plan:
- Basic frame (SIZE=4, PIPE_LAT=8, tri_ready=1):
  - frame_start at cycle 0 with camera_loc_in=30'h1234_5678 -> camera_loc=30'h1234_5678 from cycle 1.
  - issue_valid in cycles 1-4 with ram_addr 0,1,2,3.
  - 4 tri_valid beats in address order; tri_last on the 4th beat.
  - frame_done pulse one cycle after the last accept; err=0.
- Backpressure (FIFO_DEPTH=4, tri_ready=0 for 40 cycles):
  - Exactly 4 issues, then issue_valid=0 with ram_addr held.
  - After tri_ready=1, the remaining issues resume, no data is lost, and 4 beats are delivered per frame.
- Ignored start: frame_start pulses while busy=1 -> camera_loc and counters unchanged; frame completes normally.
- Spurious return: proj_valid with inflight=0 in IDLE -> no tri_valid, err=1. The next accepted frame_start clears err.
- Async reset mid-frame after 2 issues: rst_n=0 -> busy, issue_valid and tri_valid are 0 immediately. A new frame after release starts at ram_addr=0.
- Watchdog (SEQ_WATCHDOG_EN defined): datapath model suppresses the return of address 2 -> err=1 and frame_done pulse 16 cycles after the last proj_valid; state returns to IDLE with the FIFO empty.
